restoring_divider: RTL

Sequential radix-2 restoring divider: a SIZE-bit dividend by a SIZE/2-bit divisor, producing a SIZE/2-bit quotient and remainder. It is the inverse of the team's sequential Booth multiplier (SIZE/2 × SIZE/2 → SIZE) and serves as the mantissa divide path of the parametrizable FPU. Each iteration resolves one quotient bit. Divide-by-zero and quotient overflow are detected at start, and the datapath is skipped when either occurs.

---
 rtl/divider_pkg.sv | 25 ++
 rtl/div_step.sv | 30 +++
 rtl/restoring_divider.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the restoring divider.
// Holds the FSM state encoding and the error-quotient pattern.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    // Widest quotient the error pattern can cover.
    localparam int ERR_W = 256;

    // All-ones pattern in the low w bits; callers cast to their width.
    function automatic logic [ERR_W-1:0] err_quotient(input int w);
        logic [ERR_W-1:0] m;
        m = '0;
        for (int i = 0; i < ERR_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift, trial subtract, restore.
// Ports: r/q/divisor in; r_next/q_next out (N+1 / N bits).
module div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] divisor,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [N+1:0] r_sh;
    logic [N+1:0] t;

    // r[N] is always zero (r < divisor), so shifting the whole
    // register is equivalent to shifting r[N-1:0].
    assign r_sh = {r, q[N-1]};
    assign t    = r_sh - {2'b00, divisor};

    always_comb begin
        r_next = r_sh[N:0];
        q_next = {q[N-2:0], 1'b0};
        if (!t[N+1]) begin
            r_next = t[N:0];
            q_next = {q[N-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider, SIZE / (SIZE/2) -> SIZE/2.
// Ports: i_clk, i_rst (sync, high), i_start, i_dividend, i_divisor in;
//        o_quotient, o_remainder, o_busy, o_done, o_div_by_zero,
//        o_overflow out (all registered).
// Option: RESTORING_DIVIDER_SIGNED_EN enables two's-complement operands
//         with an extra FIX cycle for sign correction.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [SIZE-1:0]   i_dividend,
    input  logic [SIZE/2-1:0] i_divisor,
    output logic [SIZE/2-1:0] o_quotient,
    output logic [SIZE/2-1:0] o_remainder,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_div_by_zero,
    output logic              o_overflow
);

    localparam int N  = SIZE / 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    div_state_t    state;
    logic [N:0]    r;
    logic [N:0]    r_next;
    logic [N-1:0]  q;
    logic [N-1:0]  q_next;
    logic [N-1:0]  dvsr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  err_q;
    logic [SIZE-1:0] dd_mag;
    logic [N-1:0]  dv_mag;

    assign err_q = N'(err_quotient(N));

`ifdef RESTORING_DIVIDER_SIGNED_EN
    logic         q_neg;
    logic         r_neg;
    logic         fix_ovf;
    logic [N-1:0] q_fix;
    logic [N-1:0] r_fix;

    assign dd_mag = i_dividend[SIZE-1] ? -i_dividend : i_dividend;
    assign dv_mag = i_divisor[N-1] ? -i_divisor : i_divisor;

    // Negative results may reach -2^(N-1); positive only 2^(N-1)-1.
    assign fix_ovf = q_neg ? (q[N-1] && |q[N-2:0]) : q[N-1];
    assign q_fix   = q_neg ? -q : q;
    assign r_fix   = r_neg ? -r[N-1:0] : r[N-1:0];
`else
    assign dd_mag = i_dividend;
    assign dv_mag = i_divisor;
`endif

    div_step #(
        .N(N)
    ) u_step (
        .r      (r),
        .q      (q),
        .divisor(dvsr),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            r             <= '0;
            q             <= '0;
            dvsr          <= '0;
            cnt           <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                    if (i_start) begin
                        o_div_by_zero <= 1'b0;
                        o_overflow    <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
                        q_neg <= i_dividend[SIZE-1] ^ i_divisor[N-1];
                        r_neg <= i_dividend[SIZE-1];
`endif
                        if (dv_mag == '0) begin
                            o_div_by_zero <= 1'b1;
                            o_quotient    <= err_q;
                            o_remainder   <= '0;
                            o_done        <= 1'b1;
                            state         <= DONE;
                        end else if (dd_mag[SIZE-1:N] >= dv_mag) begin
                            o_overflow  <= 1'b1;
                            o_quotient  <= err_q;
                            o_remainder <= '0;
                            o_done      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            r      <= {1'b0, dd_mag[SIZE-1:N]};
                            q      <= dd_mag[N-1:0];
                            dvsr   <= dv_mag;
                            cnt    <= CNT_LAST;
                            o_busy <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
                        state <= FIX;
`else
                        o_quotient  <= q_next;
                        o_remainder <= r_next[N-1:0];
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                        state       <= DONE;
`endif
                    end
                end
                FIX: begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
                    if (fix_ovf) begin
                        o_overflow  <= 1'b1;
                        o_quotient  <= err_q;
                        o_remainder <= '0;
                    end else begin
                        o_quotient  <= q_fix;
                        o_remainder <= r_fix;
                    end
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= DONE;
`else
                    o_busy <= 1'b0;
                    state  <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
